bf_io_bridge: RTL
=================

// Module: bf_io_bridge
// PURPOSE
// - Host-side counterpart of the bf_machine I/O handshakes. Sources bytes into the machine's input port and sinks
//   bytes from its output port, each through a FIFO, so the interpreter never stalls on host latency.
// - Terminates the input stream with a configurable end-of-file policy. Sits between the host byte streams and bf_machine.
// PARAMETERS
// - WORD_SIZE  8     width of every data byte; matches bf_machine WORD_SIZE
// - FIFO_DEPTH 16    entries per FIFO; power of 2, >=2
// - EOF_MODE   1     0: after EOF, stop driving input (machine stalls); 1: after EOF, supply EOF_VALUE forever
// - EOF_VALUE  0     byte returned for every read after EOF when EOF_MODE=1
// PORTS
// - clk           in  1                  clock, rising edge
// - rst_n         in  1                  reset, asynchronous, active-low
// - host_in_data  in  WORD_SIZE          host byte destined for the machine
// - host_in_valid in  1                  host_in_data valid
// - host_in_ready out 1                  input FIFO can accept a byte
// - host_in_eof   in  1                  one-cycle pulse: no more input after bytes already accepted
// - mach_in_data  out WORD_SIZE          to bf_machine machine_input
// - mach_in_valid out 1                  to bf_machine machine_input_valid
// - mach_in_ready in  1                  from bf_machine machine_input_ready
// - mach_out_data in  WORD_SIZE          from bf_machine machine_output
// - mach_out_valid in 1                  from bf_machine machine_output_valid
// - mach_out_ready out 1                 to bf_machine machine_output_ready
// - host_out_data out WORD_SIZE          byte produced by the machine
// - host_out_valid out 1                 host_out_data valid
// - host_out_ready in  1                 host accepts host_out_data
// - in_level      out $clog2(FIFO_DEPTH)+1  input FIFO occupancy
// - out_level     out $clog2(FIFO_DEPTH)+1  output FIFO occupancy
// - eof_reached   out 1                  EOF latched and input FIFO drained
// BEHAVIOUR
// - Reset (rst_n=0, async): both FIFOs empty, pointers 0, state IN_STREAM; all outputs 0 except host_in_ready=1,
//   mach_out_ready=1. Counters (if built) 0. Reset mid-transfer discards all FIFO contents.
// - Transfer on any interface = valid & ready at rising clk. Both FIFOs first-word-fall-through: head byte on
//   data output same cycle valid is high. Write-to-read latency 1 cycle (written byte visible next cycle).
// - FIFO pointers are $clog2(FIFO_DEPTH)+1 bits, wrap modulo 2*FIFO_DEPTH; full = MSBs differ, rest equal.
// - host_in_ready = !in_full; mach_out_ready = !out_full; no combinational path from read side to write ready:
//   a full FIFO refuses writes even if popped in the same cycle. Simultaneous push+pop when neither full nor
//   empty: level unchanged. Push while empty and pop same cycle: pop does not see the new byte (valid was 0).
// - Input state machine:
//   IN_STREAM:   mach_in_valid = !in_empty. host_in_eof -> IN_EOF_PEND (or IN_EOF if FIFO empty and no push that cycle).
//   IN_EOF_PEND: host_in_ready=0 (further host bytes refused); drains FIFO; when last byte popped -> IN_EOF.
//   IN_EOF:      eof_reached=1; host_in_ready=0. EOF_MODE=1: mach_in_valid=1, mach_in_data=EOF_VALUE every cycle.
//                EOF_MODE=0: mach_in_valid=0. Exit only by reset.
//   host_in_eof coincident with an accepted host byte: byte is stored first, then EOF applies after it.
// - host_in_eof outside IN_STREAM ignored. mach_in_data = 0 whenever mach_in_valid=0.
// - Output side: no state machine; host_out_valid = !out_empty, host_out_data = 0 when empty.
// - in_level/out_level reflect registered state (post-edge), range 0..FIFO_DEPTH.
// CONFIGURATION
// - BF_IO_BRIDGE_COUNTERS_EN defined: adds outputs bytes_in, bytes_out (32 bits each) counting mach_in and
//   mach_out transfers (EOF_VALUE supplies counted in bytes_in), wrap at 2^32, cleared only by reset.
// - Not defined: ports absent, no counter logic; all other behaviour identical.
// TESTING
// - Push 0x41,0x42,0x43 on host_in, mach_in_ready=1 -> mach_in_data 0x41,0x42,0x43 in order, in_level returns to 0.
// - Push FIFO_DEPTH bytes with mach_in_ready=0 -> host_in_ready=0 after 16th, 17th byte not accepted, in_level=16.
// - EOF_MODE=1,EOF_VALUE=0: push 0x05 with host_in_eof same cycle -> machine reads 0x05, then 0x00 repeatedly,
//   eof_reached=1 after pop of 0x05; host_in_valid afterwards -> host_in_ready=0.
// - EOF_MODE=0: pulse host_in_eof on empty FIFO -> eof_reached=1 next cycle, mach_in_valid stays 0.
// - mach_out_valid with 0x10..0x1F, host_out_ready=0 -> mach_out_ready=0 after 16 bytes; release -> 0x10..0x1F in order.
// - rst_n low mid-stream with both FIFOs half full -> levels 0, host_out_valid=0, state IN_STREAM immediately.

Source files
------------

// File: rtl/bf_io_bridge.sv
// Host-side bridge for the bf_machine I/O handshakes: one FWFT FIFO per direction plus an end-of-file policy
// on the input stream. Optional 32-bit transfer counters are built when BF_IO_BRIDGE_COUNTERS_EN is defined.

module bf_io_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [W-1:0]           wr_data_i,
    input  logic                   wr_en_i,
    input  logic                   rd_en_i,
    output logic [W-1:0]           rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic          push_s;
    logic          pop_s;

    // Status is a pure function of the registered pointers, so ready never depends on the read side.
    always_comb begin
        full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty_o = (wr_ptr_q == rd_ptr_q);
        level_o = wr_ptr_q - rd_ptr_q;
        push_s  = wr_en_i && !full_o;
        pop_s   = rd_en_i && !empty_o;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (empty_o) begin
            rd_data_o = {W{1'b0}};
        end else begin
            rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

module bf_io_bridge #(
    parameter int WORD_SIZE  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int EOF_MODE   = 1,
    parameter int EOF_VALUE  = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WORD_SIZE-1:0]          host_in_data,
    input  logic                          host_in_valid,
    output logic                          host_in_ready,
    input  logic                          host_in_eof,
    output logic [WORD_SIZE-1:0]          mach_in_data,
    output logic                          mach_in_valid,
    input  logic                          mach_in_ready,
    input  logic [WORD_SIZE-1:0]          mach_out_data,
    input  logic                          mach_out_valid,
    output logic                          mach_out_ready,
    output logic [WORD_SIZE-1:0]          host_out_data,
    output logic                          host_out_valid,
    input  logic                          host_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   in_level,
    output logic [$clog2(FIFO_DEPTH):0]   out_level,
    output logic                          eof_reached
`ifdef BF_IO_BRIDGE_COUNTERS_EN
    ,
    output logic [31:0]                   bytes_in,
    output logic [31:0]                   bytes_out
`endif
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0] IN_STREAM   = 2'd0;
    localparam logic [1:0] IN_EOF_PEND = 2'd1;
    localparam logic [1:0] IN_EOF      = 2'd2;
    localparam logic [LW-1:0] LEVEL_ONE = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [WORD_SIZE-1:0] EOF_BYTE = WORD_SIZE'(EOF_VALUE);
    localparam logic EOF_SUPPLY = (EOF_MODE == 1);

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic                 in_full_s;
    logic                 in_empty_s;
    logic                 in_push_s;
    logic                 in_pop_s;
    logic [WORD_SIZE-1:0] in_head_s;
    logic [LW-1:0]        in_level_s;
    logic                 out_full_s;
    logic                 out_empty_s;
    logic [LW-1:0]        out_level_s;

    bf_io_fifo #(.W(WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_data_i (host_in_data),
        .wr_en_i   (in_push_s),
        .rd_en_i   (in_pop_s),
        .rd_data_o (in_head_s),
        .full_o    (in_full_s),
        .empty_o   (in_empty_s),
        .level_o   (in_level_s)
    );

    bf_io_fifo #(.W(WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_data_i (mach_out_data),
        .wr_en_i   (mach_out_valid),
        .rd_en_i   (host_out_ready),
        .rd_data_o (host_out_data),
        .full_o    (out_full_s),
        .empty_o   (out_empty_s),
        .level_o   (out_level_s)
    );

    assign mach_out_ready = !out_full_s;
    assign host_out_valid = !out_empty_s;
    assign in_level       = in_level_s;
    assign out_level      = out_level_s;
    assign eof_reached    = (state_q == IN_EOF);

    // Input-side handshakes; in IN_EOF the machine is fed by the EOF policy, never by the FIFO.
    always_comb begin
        host_in_ready = (state_q == IN_STREAM) && !in_full_s;
        in_push_s     = host_in_valid && host_in_ready;
        case (state_q)
            IN_EOF: begin
                mach_in_valid = EOF_SUPPLY;
                if (EOF_SUPPLY) begin
                    mach_in_data = EOF_BYTE;
                end else begin
                    mach_in_data = {WORD_SIZE{1'b0}};
                end
            end
            default: begin
                mach_in_valid = !in_empty_s;
                mach_in_data  = in_head_s;
            end
        endcase
        in_pop_s = mach_in_valid && mach_in_ready && (state_q != IN_EOF);
    end

    // EOF applies behind every byte already accepted, including one pushed in the EOF cycle itself.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IN_STREAM: begin
                if (host_in_eof) begin
                    if (in_empty_s && !in_push_s) begin
                        state_d = IN_EOF;
                    end else begin
                        state_d = IN_EOF_PEND;
                    end
                end else begin
                    state_d = IN_STREAM;
                end
            end
            IN_EOF_PEND: begin
                if (in_empty_s || ((in_level_s == LEVEL_ONE) && in_pop_s)) begin
                    state_d = IN_EOF;
                end else begin
                    state_d = IN_EOF_PEND;
                end
            end
            IN_EOF: begin
                state_d = IN_EOF;
            end
            default: begin
                state_d = IN_STREAM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IN_STREAM;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef BF_IO_BRIDGE_COUNTERS_EN
    logic [31:0] bytes_in_q;
    logic [31:0] bytes_out_q;

    // EOF_VALUE supplies count as input transfers; both counters wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bytes_in_q  <= 32'd0;
            bytes_out_q <= 32'd0;
        end else begin
            if (mach_in_valid && mach_in_ready) begin
                bytes_in_q <= bytes_in_q + 32'd1;
            end
            if (mach_out_valid && mach_out_ready) begin
                bytes_out_q <= bytes_out_q + 32'd1;
            end
        end
    end

    assign bytes_in  = bytes_in_q;
    assign bytes_out = bytes_out_q;
`endif
endmodule
